decoder3x8_pulse: RTL and testbench

- Sequential 3-to-8 decoder: the receive-side counterpart of the 8x3 encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line of an 8-bit strobe bus for a programmable number of cycles.
- Holds one pending code so back-to-back codes stream without bubbles.
- Sits between encoded command sources and one-hot select/strobe consumers.

---
 rtl/decoder3x8_pkg.sv | 15 +
 rtl/dec_pend_buf.sv | 30 +++
 rtl/decoder3x8_pulse.sv | 126 ++++++++++++
 tb/tb_decoder3x8_pulse.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder3x8_pkg.sv
// rtl/decoder3x8_pkg.sv - shared types, widths and one-hot helper for decoder3x8_pulse
package decoder3x8_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} dec_state_t;

  function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/dec_pend_buf.sv
// rtl/dec_pend_buf.sv - one-entry pending code register with load/drain/clear
module dec_pend_buf
  import decoder3x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              drain,
  input  logic [CODE_W-1:0] load_code,
  output logic              valid,
  output logic [CODE_W-1:0] code
);

  // load wins over drain so a same-cycle refill keeps the entry valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      code  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      code  <= load_code;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/decoder3x8_pulse.sv
// rtl/decoder3x8_pulse.sv - handshaked 3-to-8 decoder driving timed one-hot strobes
// Optional strobe_cnt output enabled by DECODER3X8_PULSE_CNT_EN.
module decoder3x8_pulse
  import decoder3x8_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  d,
  output logic              busy
`ifdef DECODER3X8_PULSE_CNT_EN
  ,
  output logic [15:0]       strobe_cnt
`endif
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  dec_state_t        state;
  logic [7:0]        cnt;
  logic              pend_valid;
  logic [CODE_W-1:0] pend_code;
  logic              xfer;
  logic              start;
  logic [CODE_W-1:0] start_code;
  logic              pend_load;
  logic              pend_drain;

  assign in_ready = ~pend_valid | ~en;
  assign xfer     = in_valid & in_ready;
  assign busy     = (state != IDLE) | pend_valid;

  dec_pend_buf u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (~en),
    .load      (pend_load),
    .drain     (pend_drain),
    .load_code (code),
    .valid     (pend_valid),
    .code      (pend_code)
  );

  // A new strobe starts from IDLE, or at the end of the last DRIVE/GAP cycle
  // when no gap follows; the pending entry outranks a same-cycle transfer.
  always_comb begin
    start      = 1'b0;
    start_code = code;
    pend_load  = 1'b0;
    pend_drain = 1'b0;
    if (en) begin
      case (state)
        IDLE: start = xfer;
        DRIVE, GAP: begin
          if (cnt == 8'd0 && (state == GAP || GAP_CYCLES == 0)) begin
            if (pend_valid) begin
              start      = 1'b1;
              start_code = pend_code;
              pend_drain = 1'b1;
              pend_load  = xfer;
            end else begin
              start = xfer;
            end
          end else begin
            pend_load = xfer;
          end
        end
        default: start = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      d     <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= 8'd0;
      d     <= '0;
    end else if (start) begin
      state <= DRIVE;
      cnt   <= HOLD_LOAD;
      d     <= onehot8(start_code);
    end else begin
      case (state)
        DRIVE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (GAP_CYCLES > 0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            d     <= '0;
          end else begin
            state <= IDLE;
            d     <= '0;
          end
        end
        GAP: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             state <= IDLE;
        end
        default: begin
          state <= IDLE;
          d     <= '0;
        end
      endcase
    end
  end

`ifdef DECODER3X8_PULSE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     strobe_cnt <= 16'd0;
    else if (start) strobe_cnt <= strobe_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_decoder3x8_pulse.sv
// tb/tb_decoder3x8_pulse.sv - scoreboard bench for decoder3x8_pulse
module tb_decoder3x8_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] code;
  logic       in_valid;
  logic [1:0] sel;

  logic       ready_a, ready_b, ready_c;
  logic [7:0] d_a, d_b, d_c;
  logic       busy_a, busy_b, busy_c;
  logic       cur_ready, cur_busy;
  logic [7:0] cur_d;
`ifdef DECODER3X8_PULSE_CNT_EN
  logic [15:0] cnt_c;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  decoder3x8_pulse #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .code(code), .in_valid(in_valid && sel == 2'd0),
    .in_ready(ready_a), .d(d_a), .busy(busy_a));

  decoder3x8_pulse #(.HOLD_CYCLES(2), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .code(code), .in_valid(in_valid && sel == 2'd1),
    .in_ready(ready_b), .d(d_b), .busy(busy_b));

  decoder3x8_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .code(code), .in_valid(in_valid && sel == 2'd2),
    .in_ready(ready_c), .d(d_c), .busy(busy_c)
`ifdef DECODER3X8_PULSE_CNT_EN
    , .strobe_cnt(cnt_c)
`endif
  );

  assign cur_ready = (sel == 2'd0) ? ready_a : (sel == 2'd1) ? ready_b : ready_c;
  assign cur_d     = (sel == 2'd0) ? d_a     : (sel == 2'd1) ? d_b     : d_c;
  assign cur_busy  = (sel == 2'd0) ? busy_a  : (sel == 2'd1) ? busy_b  : busy_c;

  // Expected d per cycle: each accepted code queues HOLD strobe cycles then GAP zeros.
  task automatic run_stream(input logic [2:0] list [8], input int n, input int hold,
                            input int gap, input string name, input bit chk_busy,
                            output bit stalled);
    int i = 0;
    int cyc = 0;
    bit xfer;
    logic [7:0] exp;
    logic [7:0] oh;
    stalled = 1'b0;
    exp_q.delete();
    while ((i < n || exp_q.size() > 0) && cyc < 200) begin
      in_valid = (i < n);
      code     = (i < n) ? list[i] : 3'd0;
      #1;
      xfer = in_valid && cur_ready;
      if (in_valid && !cur_ready) stalled = 1'b1;
      if (xfer) begin
        oh = 8'b1 << list[i];
        repeat (hold) exp_q.push_back(oh);
        repeat (gap) exp_q.push_back(8'h00);
      end
      @(posedge clk); #1;
      cyc++;
      in_valid = 1'b0;
      if (xfer) i++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      n_vec++;
      if (cur_d !== exp) begin
        n_miss++;
        $display("FAIL %s cyc%0d: d=%h expected %h", name, cyc, cur_d, exp);
      end
      if (chk_busy) begin
        n_vec++;
        if (cur_busy !== (exp != 8'h00)) begin
          n_miss++;
          $display("FAIL %s busy cyc%0d: busy=%b expected %b", name, cyc, cur_busy, exp != 8'h00);
        end
      end
    end
    n_vec++;
    if (cyc >= 200) begin
      n_miss++;
      $display("FAIL %s timeout: codes sent=%0d required %0d", name, i, n);
    end
    @(posedge clk); #1;
    n_vec++;
    if (cur_d !== 8'h00 || cur_busy !== 1'b0) begin
      n_miss++;
      $display("FAIL %s idle: d=%h busy=%b expected 00/0", name, cur_d, cur_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; code = 3'd0; sel = 2'd0;
    #1;
    n_vec++;
    if ({d_a, d_b, d_c} !== 24'h0 || {ready_a, ready_b, ready_c} !== 3'b111 ||
        {busy_a, busy_b, busy_c} !== 3'b000) begin
      n_miss++;
      $display("FAIL reset_state: d=%h ready=%b busy=%b expected 0/111/000",
               {d_a, d_b, d_c}, {ready_a, ready_b, ready_c}, {busy_a, busy_b, busy_c});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    code = 3'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    code = 3'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (d_a !== 8'h20 || ready_a !== 1'b0 || busy_a !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_pre: d=%h ready=%b busy=%b expected 20/0/1", d_a, ready_a, busy_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (d_a !== 8'h00 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_async: d=%h ready=%b busy=%b expected 00/1/0", d_a, ready_a, busy_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [2:0] l [8];
    bit st;
    l = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    sel = 2'd0;
    run_stream(l, 1, 3, 0, "single", 1'b1, st);
  endtask

  task automatic test_back_to_back();
    logic [2:0] l [8];
    bit st;
    l = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    sel = 2'd0;
    run_stream(l, 8, 3, 0, "stream", 1'b0, st);
    n_vec++;
    if (st !== 1'b1) begin
      n_miss++;
      $display("FAIL stream_stall: in_ready low seen=%b expected 1", st);
    end
  endtask

  task automatic test_gap();
    logic [2:0] l [8];
    bit st;
    l = '{3'd3, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    sel = 2'd1;
    run_stream(l, 2, 2, 2, "gap", 1'b0, st);
  endtask

  task automatic test_enable_kill();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00};
    sel = 2'd0;
    code = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    code = 3'd2;
    @(posedge clk); #1;
    n_vec++;
    if (d_a !== 8'h80 || ready_a !== 1'b0) begin
      n_miss++;
      $display("FAIL kill_setup: d=%h ready=%b expected 80/0", d_a, ready_a);
    end
    en = 1'b0; code = 3'd4;
    #1;
    n_vec++;
    if (ready_a !== 1'b1) begin
      n_miss++;
      $display("FAIL kill_ready: ready=%b expected 1", ready_a);
    end
    @(posedge clk); #1;
    n_vec++;
    if (d_a !== 8'h00 || busy_a !== 1'b0) begin
      n_miss++;
      $display("FAIL kill_trunc: d=%h busy=%b expected 00/0", d_a, busy_a);
    end
    en = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (d_a !== 8'h00 || busy_a !== 1'b0) begin
      n_miss++;
      $display("FAIL kill_dropped: d=%h busy=%b expected 00/0", d_a, busy_a);
    end
    code = 3'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++;
      if (d_a !== exp_seq[k]) begin
        n_miss++;
        $display("FAIL kill_resume cyc%0d: d=%h expected %h", k, d_a, exp_seq[k]);
      end
    end
  endtask

`ifdef DECODER3X8_PULSE_CNT_EN
  task automatic pump(input int n);
    int sent = 0;
    int cyc = 0;
    bit xfer;
    while (sent < n && cyc < 2 * n + 10) begin
      in_valid = 1'b1;
      code = 3'($urandom_range(0, 7));
      #1;
      xfer = ready_c;
      @(posedge clk); #1;
      cyc++;
      if (xfer) sent++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (sent != n) begin
      n_miss++;
      $display("FAIL pump: sent=%0d required %0d", sent, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_strobe_cnt();
    sel = 2'd2;
    pump(5);
    en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    pump(2);
    n_vec++;
    if (cnt_c !== 16'd7) begin
      n_miss++;
      $display("FAIL cnt_seven: strobe_cnt=%0d expected 7", cnt_c);
    end
    pump(65535 - 7);
    n_vec++;
    if (cnt_c !== 16'hFFFF) begin
      n_miss++;
      $display("FAIL cnt_full: strobe_cnt=%h expected ffff", cnt_c);
    end
    pump(1);
    n_vec++;
    if (cnt_c !== 16'h0000) begin
      n_miss++;
      $display("FAIL cnt_wrap: strobe_cnt=%h expected 0000", cnt_c);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_enable_kill();
`ifdef DECODER3X8_PULSE_CNT_EN
    test_strobe_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
